dma_seq_ctrl: RTL and testbench

Sequencer for the core's custom DMA instructions: DMAW (opcode 7'b1111011, word copy) and DMAB (opcode 7'b1110111, byte copy). It sits beside the execute stage and accepts the instruction together with the rs1 (source address) and rs2 (destination address) operands. It stalls the pipeline and drives a single-port memory request bus through read-then-write beats until the element count from the zero-extended 12-bit immediate, INSTR[31:20], is exhausted.

---
 rtl/dma_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dma_seq_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_seq_ctrl.sv
// DMAW/DMAB copy sequencer: stalls the pipeline and runs read-then-write beats on a single-port bus.
// Optional macro DMA_ALIGN_CHECK_EN rejects misaligned DMAW (ERR + DONE, no beats).
module dma_seq_ctrl #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 12
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ISSUE_VALID,
   input  logic [31:0]       ISSUE_INSTR,
   input  logic [ADDR_W-1:0] SRC_ADDR,
   input  logic [ADDR_W-1:0] DST_ADDR,
   output logic              ISSUE_READY,
   output logic              STALL,
   output logic              DONE,
   output logic              ERR,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [3:0]        MEM_BE,
   output logic [31:0]       MEM_WDATA,
   input  logic              MEM_GNT,
   input  logic              MEM_RVALID,
   input  logic [31:0]       MEM_RDATA
);

   localparam logic [6:0] OP_DMAW = 7'b1111011;
   localparam logic [6:0] OP_DMAB = 7'b1110111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
      S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W-1:0] step;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  len_in;
   logic              word_q, word_d;
   logic [31:0]       data_q, data_d;
   logic [7:0]        rd_byte;
   logic              is_dmaw;
   logic              is_dmab;
   logic              accept;
   logic              align_bad;
   logic              unused_instr_bits;

   assign is_dmaw = (ISSUE_INSTR[6:0] == OP_DMAW);
   assign is_dmab = (ISSUE_INSTR[6:0] == OP_DMAB);
   assign len_in  = ISSUE_INSTR[20 +: LEN_W];
   assign accept  = (state_q == S_IDLE) & ISSUE_VALID & (is_dmaw | is_dmab);
   assign unused_instr_bits = ^ISSUE_INSTR[19:7];

   assign step    = word_q ? ADDR_W'(4) : ADDR_W'(1);
   // Byte mode picks the lane addressed by the low source bits of the word just read.
   assign rd_byte = MEM_RDATA[{src_q[1:0], 3'b000} +: 8];

`ifdef DMA_ALIGN_CHECK_EN
   logic err_q;

   assign align_bad = is_dmaw & ((SRC_ADDR[1:0] != 2'b00) | (DST_ADDR[1:0] != 2'b00));

   always_ff @(posedge CLK) begin
      if (RST) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= align_bad;
      end
   end

   assign ERR = (state_q == S_FIN) & err_q;
`else
   assign align_bad = 1'b0;
   assign ERR       = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
      src_q  <= src_d;
      dst_q  <= dst_d;
      len_q  <= len_d;
      word_q <= word_d;
      data_q <= data_d;
   end

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      len_d       = len_q;
      word_d      = word_q;
      data_d      = data_q;
      ISSUE_READY = 1'b0;
      STALL       = 1'b1;
      DONE        = 1'b0;
      MEM_REQ     = 1'b0;
      MEM_WE      = 1'b0;
      MEM_ADDR    = '0;
      MEM_BE      = 4'b0000;
      MEM_WDATA   = 32'h0;

      case (state_q)
         S_IDLE: begin
            ISSUE_READY = 1'b1;
            STALL       = ISSUE_VALID & (is_dmaw | is_dmab);
            if (accept) begin
               src_d   = SRC_ADDR;
               dst_d   = DST_ADDR;
               len_d   = len_in;
               word_d  = is_dmaw;
               state_d = ((len_in == '0) | align_bad) ? S_FIN : S_RD_REQ;
            end
         end

         S_RD_REQ: begin
            MEM_REQ  = 1'b1;
            MEM_ADDR = {src_q[ADDR_W-1:2], 2'b00};
            if (MEM_GNT) begin
               state_d = S_RD_WAIT;
            end
         end

         S_RD_WAIT: begin
            if (MEM_RVALID) begin
               data_d  = word_q ? MEM_RDATA : {4{rd_byte}};
               state_d = S_WR_REQ;
            end
         end

         S_WR_REQ: begin
            MEM_REQ   = 1'b1;
            MEM_WE    = 1'b1;
            MEM_ADDR  = {dst_q[ADDR_W-1:2], 2'b00};
            MEM_BE    = word_q ? 4'b1111 : (4'b0001 << dst_q[1:0]);
            MEM_WDATA = data_q;
            if (MEM_GNT) begin
               src_d   = src_q + step;
               dst_d   = dst_q + step;
               len_d   = len_q - 1'b1;
               state_d = (len_q == LEN_W'(1)) ? S_FIN : S_RD_REQ;
            end
         end

         S_FIN: begin
            DONE    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dma_seq_ctrl.sv
// Randomized bench for dma_seq_ctrl: a transaction-level copy model and a bus responder
// check every cycle, plus literal expectations for the directed copy scenarios.
module tb_dma_seq_ctrl;

   logic        CLK = 1'b0;
   logic        RST, ISSUE_VALID;
   logic [31:0] ISSUE_INSTR, SRC_ADDR, DST_ADDR;
   logic        ISSUE_READY, STALL, DONE, ERR, MEM_REQ, MEM_WE;
   logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
   logic [3:0]  MEM_BE;
   logic        MEM_GNT, MEM_RVALID;

   always #5 CLK = ~CLK;

   dma_seq_ctrl #(.ADDR_W(32), .LEN_W(12)) dut (
      .CLK(CLK), .RST(RST), .ISSUE_VALID(ISSUE_VALID), .ISSUE_INSTR(ISSUE_INSTR),
      .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .ISSUE_READY(ISSUE_READY), .STALL(STALL),
      .DONE(DONE), .ERR(ERR), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
      .MEM_BE(MEM_BE), .MEM_WDATA(MEM_WDATA), .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID),
      .MEM_RDATA(MEM_RDATA)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // stimulus requests
   bit          irst, iv;
   logic [31:0] iinstr, isrc, idst;
   // responder configuration and state
   int          gd_min = 0, gd_max = 0, rd_min = 1, rd_max = 1;
   int          gwait = 0, gdel = 0, rvc = 0;
   bit          rvp = 0;
   logic [31:0] rv_data;
   logic [31:0] rdq[$];
   // transaction-level model
   bit          m_active = 0, m_fin = 0, m_err = 0, m_req = 0, m_we = 0, m_wait = 0, m_word = 0;
   logic [31:0] m_src, m_dst, m_data;
   int          m_left;
   // observation logs
   logic [31:0] rlog[$], wa[$], wd[$];
   logic [3:0]  wb[$];
   int          done_cnt = 0, err_cnt = 0, stall_cnt = 0, req_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
   endfunction

   task automatic model_reset();
      m_active = 0; m_fin = 0; m_err = 0; m_req = 0; m_we = 0; m_wait = 0;
      rvp = 0; gwait = 0; gdel = $urandom_range(gd_min, gd_max);
   endtask

   task automatic cyc();
      bit g, is_dma;
      logic [31:0] xa;
      @(negedge CLK);
      RST = irst; ISSUE_VALID = iv; ISSUE_INSTR = iinstr; SRC_ADDR = isrc; DST_ADDR = idst;
      g = MEM_REQ && (gwait >= gdel);
      MEM_GNT = g;
      if (rvp && rvc == 1) begin
         MEM_RVALID = 1'b1; MEM_RDATA = rv_data;
      end else begin
         MEM_RVALID = 1'b0; MEM_RDATA = $urandom;
      end
      #1;
      is_dma = iv && (iinstr[6:0] == 7'b1111011 || iinstr[6:0] == 7'b1110111);
      if (chk_en) begin
         chk("ready", ISSUE_READY, !m_active);
         chk("stall", STALL, m_active || is_dma);
         chk("done", DONE, m_fin);
         chk("err", ERR, m_fin && m_err);
         chk("mem_req", MEM_REQ, m_req);
         if (m_req) begin
            chk("mem_we", MEM_WE, m_we);
            xa = m_we ? m_dst : m_src;
            chk("mem_addr", MEM_ADDR, {xa[31:2], 2'b00});
            if (m_we) begin
               chk("mem_be", MEM_BE, m_word ? 4'hF : (4'h1 << m_dst[1:0]));
               chk("mem_wdata", MEM_WDATA, m_data);
            end
         end
      end
      if (DONE) done_cnt++;
      if (ERR) err_cnt++;
      if (STALL) stall_cnt++;
      if (MEM_REQ) req_cnt++;
      if (MEM_REQ && g && !irst) begin
         if (MEM_WE) begin
            wa.push_back(MEM_ADDR); wb.push_back(MEM_BE); wd.push_back(MEM_WDATA);
         end else begin
            rlog.push_back(MEM_ADDR);
         end
      end
      // advance responder and model to the state following this clock edge
      if (rvp) begin
         rvc--;
         if (rvc == 0) rvp = 0;
      end
      if (MEM_REQ) begin
         if (g) begin
            gwait = 0;
            gdel = $urandom_range(gd_min, gd_max);
            if (!MEM_WE) begin
               rvp = 1;
               rvc = $urandom_range(rd_min, rd_max);
               rv_data = (rdq.size() > 0) ? rdq.pop_front() : memf(MEM_ADDR);
            end
         end else begin
            gwait++;
         end
      end
      if (irst) begin
         model_reset();
      end else if (m_fin) begin
         m_fin = 0; m_active = 0;
      end else if (!m_active) begin
         if (is_dma) begin
            m_active = 1;
            m_word = (iinstr[6:0] == 7'b1111011);
            m_src = isrc; m_dst = idst; m_left = int'(iinstr[31:20]);
`ifdef DMA_ALIGN_CHECK_EN
            m_err = m_word && (isrc[1:0] != 2'b00 || idst[1:0] != 2'b00);
`else
            m_err = 0;
`endif
            if (m_left == 0 || m_err) m_fin = 1;
            else begin m_req = 1; m_we = 0; end
         end
      end else if (m_req && g) begin
         if (!m_we) begin
            m_req = 0; m_wait = 1;
         end else begin
            m_src = m_src + (m_word ? 32'd4 : 32'd1);
            m_dst = m_dst + (m_word ? 32'd4 : 32'd1);
            m_left--;
            if (m_left == 0) begin m_req = 0; m_fin = 1; end
            else m_we = 0;
         end
      end else if (m_wait && MEM_RVALID) begin
         m_data = m_word ? MEM_RDATA : {4{MEM_RDATA[{m_src[1:0], 3'b000} +: 8]}};
         m_wait = 0; m_req = 1; m_we = 1;
      end
   endtask

   task automatic clear_logs();
      rlog.delete(); wa.delete(); wb.delete(); wd.delete();
      done_cnt = 0; err_cnt = 0; req_cnt = 0;
   endtask

   task automatic issue(input bit word, input logic [31:0] s, input logic [31:0] d, input int len);
      iinstr = {len[11:0], 13'($urandom), (word ? 7'b1111011 : 7'b1110111)};
      isrc = s; idst = d; iv = 1;
      cyc();
      iv = 0;
      stall_cnt = 0;
   endtask

   task automatic wait_idle(input string name, input bit noise);
      int n = 0;
      while (m_active && n < 5000) begin
         iv = noise && m_active && ($urandom_range(0, 1) == 1);
         if (iv) iinstr = {$urandom} & 32'hFFFF_FF80 | 32'h7B;
         cyc();
         n++;
      end
      iv = 0;
      chk({"timeout_", name}, m_active, 0);
   endtask

   initial begin
      int len;
      logic [31:0] s, d;
      irst = 1; iv = 0; iinstr = 0; isrc = 0; idst = 0;
      MEM_GNT = 0; MEM_RVALID = 0; MEM_RDATA = 0;
      cyc(); cyc();
      model_reset();
      irst = 0; chk_en = 1;
      cyc();
      chk("rst_ready", ISSUE_READY, 1);
      chk("rst_stall", STALL, 0);
      chk("rst_req", MEM_REQ, 0);
      chk("rst_addr", MEM_ADDR, 0);
      chk("rst_be", MEM_BE, 0);
      chk("rst_wdata", MEM_WDATA, 0);

      // word copy, zero-wait memory
      clear_logs();
      rdq = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
      issue(1, 32'h1000, 32'h2000, 3);
      wait_idle("t1", 0);
      chk("t1_nrd", rlog.size(), 3);
      chk("t1_nwr", wa.size(), 3);
      if (rlog.size() == 3 && wa.size() == 3) begin
         chk("t1_rd2", rlog[2], 32'h1008);
         chk("t1_wa0", wa[0], 32'h2000);
         chk("t1_wa2", wa[2], 32'h2008);
         chk("t1_wb1", wb[1], 4'hF);
         chk("t1_wd0", wd[0], 32'h01020304);
         chk("t1_wd2", wd[2], 32'h090A0B0C);
      end
      chk("t1_stall", stall_cnt, 10);
      chk("t1_done", done_cnt, 1);

      // byte copy across lanes
      clear_logs();
      rdq = '{32'hAABBCCDD, 32'h11223344};
      issue(0, 32'h1001, 32'h2003, 2);
      wait_idle("t2", 0);
      chk("t2_nwr", wa.size(), 2);
      if (wa.size() == 2) begin
         chk("t2_wa0", wa[0], 32'h2000);
         chk("t2_wb0", wb[0], 4'b1000);
         chk("t2_wd0", wd[0], 32'hCCCCCCCC);
         chk("t2_wa1", wa[1], 32'h2004);
         chk("t2_wb1", wb[1], 4'b0001);
         chk("t2_wd1", wd[1], 32'h22222222);
      end

      // zero-length copy
      clear_logs();
      issue(1, 32'h1000, 32'h2000, 0);
      cyc();
      chk("t3_done", DONE, 1);
      wait_idle("t3", 0);
      chk("t3_stall", stall_cnt, 1);
      chk("t3_req", req_cnt, 0);

      // slow grant and late read data
      clear_logs();
      gd_min = 4; gd_max = 4; rd_min = 3; rd_max = 3; gdel = 4;
      issue(1, 32'h3000, 32'h4000, 3);
      wait_idle("t4", 1);
      chk("t4_nwr", wa.size(), 3);
      if (wd.size() == 3) begin
         chk("t4_wd0", wd[0], memf(32'h3000));
         chk("t4_wd2", wd[2], memf(32'h3008));
      end
      chk("t4_done", done_cnt, 1);

      // reset during the second write of a five-element copy
      clear_logs();
      gd_min = 2; gd_max = 2; rd_min = 1; rd_max = 1; gdel = 2; gwait = 0;
      issue(1, 32'h5000, 32'h6000, 5);
      begin
         int n = 0;
         while (!(wa.size() == 1 && MEM_REQ && MEM_WE && !MEM_GNT) && n < 200) begin
            cyc(); n++;
         end
         chk("t5_reach", n < 200, 1);
      end
      irst = 1; cyc(); irst = 0;
      cyc();
      chk("t5_ready", ISSUE_READY, 1);
      chk("t5_req", MEM_REQ, 0);
      chk("t5_done", done_cnt, 0);
      gd_min = 0; gd_max = 0; gdel = 0;
      rdq = '{32'h55667788};
      issue(0, 32'h7002, 32'h8001, 1);
      wait_idle("t5b", 0);
      chk("t5_done2", done_cnt, 1);
      if (wa.size() == 2) begin
         chk("t5_wa", wa[1], 32'h8000);
         chk("t5_wb", wb[1], 4'b0010);
         chk("t5_wd", wd[1], 32'h66666666);
      end else chk("t5_nwr", wa.size(), 2);

      // misaligned word copy
      clear_logs();
      issue(1, 32'h1002, 32'h2000, 2);
      wait_idle("t6", 0);
      chk("t6_done", done_cnt, 1);
`ifdef DMA_ALIGN_CHECK_EN
      chk("t6_err", err_cnt, 1);
      chk("t6_nrd", rlog.size(), 0);
`else
      chk("t6_err", err_cnt, 0);
      chk("t6_nrd", rlog.size(), 2);
      if (rlog.size() > 0) chk("t6_rd0", rlog[0], 32'h1000);
`endif

      // randomized traffic
      gd_min = 0; gd_max = 3; rd_min = 1; rd_max = 3;
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            iinstr = {$urandom} & 32'hFFFF_FF80 | 32'h33;
            iv = 1; cyc(); iv = 0;
         end
         s = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         d = $urandom;
         len = $urandom_range(0, 6);
         issue($urandom_range(0, 1) == 1, s, d, len);
         if ($urandom_range(0, 7) == 0) begin
            for (int k = 0; k < int'($urandom_range(0, 8)); k++) cyc();
            irst = 1; cyc(); irst = 0;
         end
         wait_idle("rand", 1);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
